// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam logic [31:0] WORD_INC         = 32'd4;
  localparam int          BURST_MAX_DEF    = 16;
  localparam int          STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/dmem_burst_seq.sv
// rtl/dmem_burst_seq.sv - DMA burst address/word-count sequencer
module dmem_burst_seq
  import dmem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] base_i,
  input  logic [7:0]  len_i,
  input  logic        step_i,
  output logic [31:0] addr_o,
  output logic        last_o
);

  logic [31:0] addr_q, addr_d;
  logic [7:0]  remain_q, remain_d;

  // Load a new burst, or advance one word per issued DMA access
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load_i) begin
      addr_d   = {base_i[31:2], 2'b00};
      remain_d = len_i;
    end else if (step_i) begin
      addr_d   = addr_q + WORD_INC;
      remain_d = remain_q - 8'd1;
    end
  end

  // Sequencer registers; a reset abandons any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (remain_q == 8'd1);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter for the single-port data memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int BURST_MAX    = BURST_MAX_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req_valid,
  output logic        dma_req_ready,
  input  logic        dma_we,
  input  logic [31:0] dma_base,
  input  logic [7:0]  dma_len,
  input  logic        dma_wvalid,
  output logic        dma_wready,
  input  logic [31:0] dma_wdata,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_done,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] BMAX = 8'(BURST_MAX);
  localparam logic [7:0] SLIM = 8'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [7:0]  starve_q, starve_d;
  logic        done_q, done_d;
  logic [31:0] mem_addr_q, mem_wdata_q;

  logic        cmd_fire, in_burst, dma_can, cpu_grant, dma_grant, seq_last;
  logic [7:0]  len_eff;
  logic [31:0] seq_addr;
  logic        unused_base;

  // Byte offset of the burst base is meaningless for word bursts
  assign unused_base = ^dma_base[1:0];

  assign in_burst  = (state_q == BURST);
  assign cmd_fire  = !in_burst && dma_req_valid;
  assign len_eff   = (dma_len > BMAX) ? BMAX : dma_len;
  assign dma_can   = we_q ? dma_wvalid : 1'b1;
  assign cpu_grant = cpu_req && (!in_burst || !dma_can || (starve_q < SLIM));
  assign dma_grant = !cpu_grant && in_burst && dma_can;

  dmem_burst_seq u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cmd_fire),
    .base_i (dma_base),
    .len_i  (len_eff),
    .step_i (dma_grant),
    .addr_o (seq_addr),
    .last_o (seq_last)
  );

  // Next state, starvation count and completion pulse
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    starve_d = starve_q;
    done_d   = 1'b0;
    if (cmd_fire) begin
      we_d = dma_we;
      if (len_eff == 8'd0) done_d = 1'b1;
      else                 state_d = BURST;
    end
    if (dma_grant) begin
      starve_d = '0;
      if (seq_last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (cpu_grant && in_burst && dma_can && (starve_q != 8'hFF)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Memory port mux; address and write data hold their last value when idle
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if (cpu_grant) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_grant) begin
      mem_we    = we_q;
      mem_addr  = seq_addr;
      mem_wdata = dma_wdata;
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      starve_q    <= '0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      starve_q    <= starve_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
    end
  end

  assign cpu_stall     = cpu_req && !cpu_grant;
  assign cpu_rdata     = mem_rdata;
  assign dma_rdata     = mem_rdata;
  assign dma_req_ready = !in_burst;
  assign dma_wready    = dma_grant && we_q;
  assign dma_rvalid    = dma_grant && !we_q;
  assign dma_done      = done_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline memory stage (CPU port) and a burst DMA/loader port. CPU accesses win by default, so they normally see zero wait states. A starvation counter guarantees DMA progress while a burst is in flight. The block sits between the memory stage and `data_mem`, and it drives a stall to the hazard unit whenever the CPU is denied.

## Interface
- `BURST_MAX`, 16: maximum words per DMA burst (1..255).
- `STARVE_LIMIT`, 4: consecutive CPU grants allowed while a DMA word is ready before DMA is forced a slot (≥1).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: memory stage performs a load or store this cycle.
- `cpu_we` in 1: store when 1.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data.
- `cpu_rdata` out 32: load data (valid when granted).
- `cpu_stall` out 1: CPU access not performed this cycle; pipeline must hold M stage.
- `dma_req_valid` / `dma_req_ready` in/out 1: burst command handshake.
- `dma_we` in 1: burst is a write.
- `dma_base` in 32: burst start byte address; bits [1:0] ignored.
- `dma_len` in 8: word count, 0..`BURST_MAX`.
- `dma_wvalid` in 1 / `dma_wready` out 1 / `dma_wdata` in 32: write word stream.
- `dma_rvalid` out 1 / `dma_rdata` out 32: read word stream (no backpressure).
- `dma_done` out 1: one-cycle pulse when a burst completes.
- `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_rdata` in 32: data memory port. The memory has a combinational read and a synchronous write.

## Operation
- **States:** IDLE and BURST, held in registers together with `addr_q`, `remain_q`, `we_q` and `starve_q`.
- **IDLE:**
  - `dma_req_ready`=1.
  - On valid&ready, latch `{dma_base[31:2],2'b00}`, `dma_len` and `dma_we`.
  - If `len`>0, go to BURST.
  - If `len`=0, stay in IDLE and pulse `dma_done` next cycle.
  - `len`>`BURST_MAX` is clamped to `BURST_MAX`.
- **BURST:**
  - `dma_req_ready`=0.
  - `dma_can` = `we_q` ? `dma_wvalid` : 1.
- **Grant rule (combinational from registered state):**
  - CPU is granted if `cpu_req` and (state==IDLE, or !`dma_can`, or `starve_q` < `STARVE_LIMIT`).
  - Otherwise DMA is granted if BURST and `dma_can`.
  - Otherwise the memory is idle: `mem_we`=0 and `mem_addr` holds its last value.
- **DMA word issue:**
  - `mem_addr`=`addr_q` and `mem_we`=`we_q`.
  - Writes: `dma_wready`=1.
  - Reads: `dma_rvalid`=1 and `dma_rdata`=`mem_rdata`.
  - Then `addr_q`+=4 (wraps mod 2^32), `remain_q`-=1, `starve_q`←0.
- **Starvation counter:** `starve_q` increments (saturating) when the CPU is granted in BURST while `dma_can`=1. It is unchanged otherwise.
- **Burst end:** when the last word issues (`remain_q`==1), go to IDLE and pulse `dma_done` in the following cycle.
- **CPU outputs:**
  - `cpu_stall` = `cpu_req` & !cpu_grant.
  - `cpu_rdata`=`mem_rdata` when granted.
- **Reset, including mid-burst:**
  - State IDLE; `addr_q`, `remain_q`, `starve_q` = 0.
  - No `dma_done` pulse; the aborted burst is not resumed.
  - Outputs: `dma_req_ready`=1; `cpu_stall`=0 (given `cpu_req`=0); `dma_done`, `dma_rvalid`, `dma_wready` and `mem_we` = 0; `mem_addr`, `mem_wdata`, `cpu_rdata`, `dma_rdata` = 0 where registered, else follow `mem_rdata`.

## Timing
- CPU latency is zero wait states when granted. Load data arrives in the same cycle; a store commits at the next rising edge.
- A stalled CPU access retries every cycle with no queuing. The CPU waits at most one cycle per `STARVE_LIMIT`+1 cycles of a burst.
- Command to first DMA word: the earliest issue is the cycle after the command handshake.
- A burst of N words with no CPU traffic takes N cycles. `dma_done` is asserted in cycle N+1 after the first issue.
- DMA read data is valid only in the `dma_rvalid` cycle; the consumer must accept it.
- Simultaneous command acceptance and CPU request in IDLE: the CPU is granted and the command is latched.
- A new command cannot be accepted during the `dma_done` cycle's preceding last-word cycle. It can be accepted in the `dma_done` cycle.

## Structure
- Package `dmem_arb_pkg`:
  - typedef enum `arb_state_t` {IDLE, BURST};
  - word-address increment constant (4);
  - `BURST_MAX` default.
- One natural sub-module, `dmem_burst_seq`: `addr_q`/`remain_q` load, increment and decrement, and last-word detect. Grant logic and the starvation counter stay in the top module.

## Test plan
- **CPU only, IDLE:** store 0xDEADBEEF to 0x40, then load 0x40 → `cpu_stall`=0 for both; `cpu_rdata`=0xDEADBEEF.
- **DMA write burst:** base 0x100, len 4, `wvalid` held high, no CPU traffic → 0x100, 0x104, 0x108, 0x10C written on consecutive cycles; `dma_done` pulses in cycle 5.
- **Starvation, `STARVE_LIMIT`=4:** read burst len 3 with `cpu_req` continuously high → grant pattern CPU×4, DMA, CPU×4, DMA, CPU×4, DMA; `cpu_stall` high exactly 3 cycles.
- **Write-data bubble:** `dma_wvalid` low during a burst with `cpu_req`=1 → CPU granted, `starve_q` unchanged, no memory write from DMA.
- **Edge cases:** `dma_len`=0 → no memory access, `dma_done` pulse next cycle. Base 0xFFFFFFF8, len 3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- **Reset mid-burst:** `rst_n` low after 2 of 5 words → state IDLE, `dma_req_ready`=1, no `dma_done`, no further DMA accesses.
